// File: rtl/io_ccff_pkg.sv
// io_ccff_pkg: shared FSM state encoding and counter width helper
// for the IO configuration-chain loader.
package io_ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } ccff_state_e;

    // Wide enough for SETTLE_CYC up to 15
    localparam int SETTLE_W = 4;

    // Bits needed to count 0..n inclusive
    function automatic int ccff_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: one-word buffer presenting its bits LSB first.
// Ports: clk_i/rst_ni (sync, active-low), clr_i (wipe data and bits),
//   flush_i (drop unshifted bits, keep head), load_i/data_i (new word),
//   shift_i (consume head bit), head_o (current bit), empty_o, last_o.
module ccff_word_serializer
    import io_ccff_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              shift_i,
    output logic              head_o,
    output logic              empty_o,
    output logic              last_o
);

    localparam int LW = ccff_cnt_w(WORD_W);
    localparam logic [LW-1:0] FULL = LW'(WORD_W);
    localparam logic [LW-1:0] ONE  = LW'(1);

    logic [WORD_W-1:0] data_q, data_d;
    logic [LW-1:0]     left_q, left_d;

    always_comb begin
        data_d = data_q;
        left_d = left_q;
        if (clr_i) begin
            data_d = '0;
            left_d = '0;
        end else if (flush_i) begin
            left_d = '0;
        end else if (load_i) begin
            data_d = data_i;
            left_d = FULL;
        end else if (shift_i && left_q != '0) begin
            left_d = left_q - ONE;
            // The final bit stays in place so the chain input holds
            // its last value while the buffer is empty.
            if (left_q != ONE) begin
                data_d = data_q >> 1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
            left_q <= '0;
        end else begin
            data_q <= data_d;
            left_q <= left_d;
        end
    end

    assign head_o  = data_q[0];
    assign empty_o = (left_q == '0);
    assign last_o  = (left_q == ONE);

endmodule

// File: rtl/io_ccff_loader.sv
// io_ccff_loader: streams bitstream words into the IO configuration
// chain, waits a settle period, then releases IO isolation.
// Ports: prog_clk, pReset_n (sync, active-low), start, abort,
//   word_data/word_valid/word_ready (input stream), ccff_head,
//   ccff_shift_en, ccff_tail (chain), IO_ISOL_N, busy, done, err.
module io_ccff_loader
    import io_ccff_pkg::*;
#(
    parameter int CHAIN_LEN  = 64,
    parameter int WORD_W     = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = ccff_cnt_w(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [SETTLE_W-1:0] SET_ONE    = SETTLE_W'(1);

    ccff_state_e         state_q;
    logic [CW-1:0]       cnt_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                iso_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic buf_empty;
    logic buf_last;
    logic in_load;
    logic kick;
    logic kill;
    logic accept;
    logic final_shift;

    // The tail is observed only by external bit-count accounting
    logic unused_tail;
    assign unused_tail = ccff_tail;

    assign in_load = (state_q == ST_LOAD);
    assign kick    = start & (state_q == ST_IDLE || state_q == ST_DONE);
    assign kill    = abort & (in_load || state_q == ST_SETTLE);

    assign ccff_shift_en = in_load & ~buf_empty;
    assign final_shift   = ccff_shift_en & (cnt_q == LAST_IDX);

    // Taking a word while the last buffered bit shifts keeps the
    // stream gapless, unless that bit completes the chain.
    assign word_ready = in_load &
        (buf_empty | (buf_last & (cnt_q < LAST_IDX)));
    assign accept = word_valid & word_ready;

    ccff_word_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .clk_i  (prog_clk),
        .rst_ni (pReset_n),
        .clr_i  (kick),
        .flush_i(kill | final_shift),
        .load_i (accept),
        .data_i (word_data),
        .shift_i(ccff_shift_en),
        .head_o (ccff_head),
        .empty_o(buf_empty),
        .last_o (buf_last)
    );

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            iso_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (kick) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        iso_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (kill) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (ccff_shift_en) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (final_shift) begin
                            state_q  <= ST_SETTLE;
                            settle_q <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (kill) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (settle_q == SETTLE_END) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        iso_q   <= 1'b1;
                    end else begin
                        settle_q <= settle_q + SET_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IO_ISOL_N = iso_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_io_ccff_loader.sv
// tb_io_ccff_loader: self-checking bench for io_ccff_loader using a
// 64-bit and a 20-bit chain instance.
module tb_io_ccff_loader;

    localparam int CL0    = 64;
    localparam int CL1    = 20;
    localparam int SETTLE = 2;

    logic       prog_clk = 1'b0;
    logic       pReset_n = 1'b0;
    logic       start [2];
    logic       abort [2];
    logic       wv    [2];
    logic [7:0] wd    [2];
    logic       rdy   [2];
    logic       head  [2];
    logic       shen  [2];
    logic       tail  [2];
    logic       iso   [2];
    logic       busy  [2];
    logic       done  [2];
    logic       err   [2];

    always #5 prog_clk = ~prog_clk;

    io_ccff_loader #(.CHAIN_LEN(CL0), .WORD_W(8), .SETTLE_CYC(SETTLE)) u0 (
        .prog_clk(prog_clk), .pReset_n(pReset_n),
        .start(start[0]), .abort(abort[0]),
        .word_data(wd[0]), .word_valid(wv[0]), .word_ready(rdy[0]),
        .ccff_head(head[0]), .ccff_shift_en(shen[0]), .ccff_tail(tail[0]),
        .IO_ISOL_N(iso[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    io_ccff_loader #(.CHAIN_LEN(CL1), .WORD_W(8), .SETTLE_CYC(SETTLE)) u1 (
        .prog_clk(prog_clk), .pReset_n(pReset_n),
        .start(start[1]), .abort(abort[1]),
        .word_data(wd[1]), .word_valid(wv[1]), .word_ready(rdy[1]),
        .ccff_head(head[1]), .ccff_shift_en(shen[1]), .ccff_tail(tail[1]),
        .IO_ISOL_N(iso[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clen(input int d);
        return (d == 0) ? CL0 : CL1;
    endfunction

    // Monitor: records the shifted bit stream and accepted words of
    // the instance under test, and checks head stability in bubbles.
    int         cur = 0;
    int         cyc = 0;
    bit         shq[$];
    logic [7:0] accq[$];
    int         first_sh = -1;
    int         last_sh = -1;
    int         iso_rise = -1;
    logic       p_sh = 1'b0;
    logic       p_busy = 1'b0;
    logic       p_head = 1'b0;
    logic       p_iso = 1'b0;

    always @(negedge prog_clk) begin
        cyc++;
        if (shen[cur] === 1'b1) begin
            shq.push_back(head[cur]);
            if (first_sh < 0) first_sh = cyc;
            last_sh = cyc;
        end
        if (wv[cur] === 1'b1 && rdy[cur] === 1'b1)
            accq.push_back(wd[cur]);
        if (iso[cur] === 1'b1 && p_iso !== 1'b1 && iso_rise < 0)
            iso_rise = cyc;
        if (p_busy && busy[cur] && !p_sh && !shen[cur])
            chk("head_hold", {31'd0, head[cur]}, {31'd0, p_head});
        p_sh   = shen[cur];
        p_busy = busy[cur];
        p_head = head[cur];
        p_iso  = iso[cur];
    end

    logic [7:0] words [16];

    task automatic chk_reset_vals(input int d, input string tag);
        chk({tag, "_iso"},  {31'd0, iso[d]},  0);
        chk({tag, "_head"}, {31'd0, head[d]}, 0);
        chk({tag, "_shen"}, {31'd0, shen[d]}, 0);
        chk({tag, "_rdy"},  {31'd0, rdy[d]},  0);
        chk({tag, "_busy"}, {31'd0, busy[d]}, 0);
        chk({tag, "_done"}, {31'd0, done[d]}, 0);
        chk({tag, "_err"},  {31'd0, err[d]},  0);
    endtask

    // mode 0: valid held high; mode 1: random valid and stray starts.
    // stop_at > 0 ends the load by abort (or reset) after that many bits.
    task automatic run_load(input int d, input int mode, input int gap_at,
                            input int gap_len, input int stop_at,
                            input bit by_reset, input int exp_bub);
        int k;
        int t;
        int gap;
        int n;
        int mism;
        bit acc;
        bit ok;
        logic [7:0] w;
        cur = d;
        shq.delete();
        accq.delete();
        first_sh = -1;
        last_sh  = -1;
        iso_rise = -1;
        @(posedge prog_clk); #1;
        start[d] = 1'b1;
        @(posedge prog_clk); #1;
        start[d] = 1'b0;
        chk("start_busy", {31'd0, busy[d]}, 1);
        chk("start_err",  {31'd0, err[d]},  0);
        chk("start_iso",  {31'd0, iso[d]},  0);
        chk("start_done", {31'd0, done[d]}, 0);
        k = 0; t = 0; gap = 0; ok = 0;
        while (t < 3000) begin
            if (gap == 0 && gap_len > 0 && k == gap_at && rdy[d]) begin
                gap = gap_len;
                gap_len = 0;
            end
            if (gap > 0) begin
                wv[d] = 1'b0;
                gap--;
            end else begin
                wv[d] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            wd[d] = words[k % 16];
            if (mode == 1) start[d] = ($urandom_range(0, 15) == 0);
            if (stop_at > 0 && shq.size() >= stop_at) begin
                if (by_reset) pReset_n = 1'b0;
                else begin
                    abort[d] = 1'b1;
                    start[d] = 1'b1;
                end
            end
            acc = wv[d] & rdy[d];
            @(posedge prog_clk); #1;
            t++;
            if (acc) k++;
            start[d] = 1'b0;
            if (abort[d]) begin
                abort[d] = 1'b0;
                wv[d] = 1'b0;
                chk("abort_busy", {31'd0, busy[d]}, 0);
                chk("abort_err",  {31'd0, err[d]},  1);
                chk("abort_iso",  {31'd0, iso[d]},  0);
                chk("abort_shen", {31'd0, shen[d]}, 0);
                chk("abort_rdy",  {31'd0, rdy[d]},  0);
                chk("abort_done", {31'd0, done[d]}, 0);
                return;
            end
            if (!pReset_n) begin
                wv[d] = 1'b0;
                chk_reset_vals(d, "midrst");
                pReset_n = 1'b1;
                return;
            end
            if (done[d]) begin
                ok = 1;
                break;
            end
        end
        wv[d] = 1'b0;
        chk("load_timeout", {31'd0, ok}, 1);
        @(negedge prog_clk); #1;
        n = clen(d);
        chk("shift_cnt", shq.size(), n);
        chk("words_acc", accq.size(), (n + 7) / 8);
        mism = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= shq.size() || (i / 8) >= accq.size()) mism++;
            else begin
                w = accq[i / 8];
                if (shq[i] != w[i % 8]) mism++;
            end
        end
        chk("stream", mism, 0);
        chk("settle_gap", iso_rise - last_sh, SETTLE + 1);
        if (exp_bub >= 0)
            chk("bubbles", (last_sh - first_sh + 1) - n, exp_bub);
        chk("end_done", {31'd0, done[d]}, 1);
        chk("end_iso",  {31'd0, iso[d]},  1);
        chk("end_busy", {31'd0, busy[d]}, 0);
        chk("end_err",  {31'd0, err[d]},  0);
    endtask

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
        logic [19:0] exp;
        int          gap;
    } vec_t;

    vec_t vt[3];

    task automatic rand_words();
        for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    endtask

    initial begin
        logic [19:0] got;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            abort[d] = 1'b0;
            wv[d]    = 1'b0;
            wd[d]    = 8'h00;
            tail[d]  = 1'b0;
        end
        vt[0] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'hFF, exp: 20'hF3CA5, gap: 0};
        vt[1] = '{w0: 8'h00, w1: 8'hFF, w2: 8'h0F, exp: 20'hFFF00, gap: 3};
        vt[2] = '{w0: 8'h12, w1: 8'h34, w2: 8'h56, exp: 20'h63412, gap: 0};

        pReset_n = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        chk_reset_vals(0, "rst0");
        chk_reset_vals(1, "rst1");
        pReset_n = 1'b1;

        rand_words();
        run_load(0, 0, 0, 0, 0, 1'b0, 0);

        for (int v = 0; v < 3; v++) begin
            rand_words();
            words[0] = vt[v].w0;
            words[1] = vt[v].w1;
            words[2] = vt[v].w2;
            run_load(1, 0, 1, vt[v].gap, 0, 1'b0, vt[v].gap);
            got = '0;
            for (int i = 0; i < 20; i++)
                if (i < shq.size()) got[i] = shq[i];
            chk("vec_stream", {12'd0, got}, {12'd0, vt[v].exp});
        end

        rand_words();
        run_load(0, 0, 0, 0, 30, 1'b0, 0);
        rand_words();
        run_load(0, 0, 0, 0, 0, 1'b0, 0);

        rand_words();
        run_load(0, 0, 0, 0, 10, 1'b1, 0);
        rand_words();
        run_load(0, 0, 0, 0, 0, 1'b0, 0);

        rand_words();
        run_load(0, 0, 0, 0, 0, 1'b0, 0);

        for (int r = 0; r < 5; r++) begin
            rand_words();
            run_load(0, 1, 0, 0, 0, 1'b0, -1);
        end
        for (int r = 0; r < 3; r++) begin
            rand_words();
            run_load(1, 1, 0, 0, 0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
